// File: rtl/dmux_4way.sv
`default_nettype none
// ============================================================================
// Module   : dmux_4way
// Purpose  : Registered 1-to-4 demultiplexer. Routes din to one of a/b/c/d
//            selected by {s1,s2}. The three unselected outputs are forced to
//            zero. A one-hot valid marks the selected route. Latency is one
//            cycle, and the block accepts one beat per cycle.
// Ports    : clk     - rising-edge clock
//            rst_n   - synchronous active-low reset
//            din     - WIDTH-bit data to route
//            s1, s2  - route select (s1 = MSB)
//            in_vld  - beat qualifier
//            a..d    - routed data, routes 0..3
//            out_vld - one-hot valid (bit0 = a ... bit3 = d)
//            cnt_a..cnt_d - saturating per-route beat counters
//                      (present only with DMUX_4WAY_CNT_EN)
// Config   : `define DMUX_4WAY_CNT_EN to add the CNT_W parameter and the
//            route counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmux_4way #(
  parameter int WIDTH = 1
`ifdef DMUX_4WAY_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             s1,
  input  logic             s2,
  input  logic             in_vld,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       out_vld
`ifdef DMUX_4WAY_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
`endif
);

  logic [1:0]       w_sel;
  logic [3:0]       w_hot;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [3:0]       r_vld;

  assign w_sel = {s1, s2};

  // The valid qualifier is tested first so that an unknown select during an
  // idle cycle cannot propagate into the route enables.
  always_comb begin
    w_hot = 4'b0000;
    if (in_vld) begin
      case (w_sel)
        2'd0:    w_hot = 4'b0001;
        2'd1:    w_hot = 4'b0010;
        2'd2:    w_hot = 4'b0100;
        default: w_hot = 4'b1000;
      endcase
    end
  end

  // Every output register reloads on every edge. Unselected routes therefore
  // drop to zero on the same edge that the newly selected route loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_d   <= '0;
      r_vld <= 4'b0000;
    end else begin
      r_a   <= w_hot[0] ? din : '0;
      r_b   <= w_hot[1] ? din : '0;
      r_c   <= w_hot[2] ? din : '0;
      r_d   <= w_hot[3] ? din : '0;
      r_vld <= w_hot;
    end
  end

  assign a       = r_a;
  assign b       = r_b;
  assign c       = r_c;
  assign d       = r_d;
  assign out_vld = r_vld;

`ifdef DMUX_4WAY_CNT_EN
  logic [CNT_W-1:0] r_cnt [4];

  // One saturating counter per route. Each counter advances on the same
  // route-enable that loads the corresponding data register.
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt[i] <= '0;
      end else if (w_hot[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign cnt_a = r_cnt[0];
  assign cnt_b = r_cnt[1];
  assign cnt_c = r_cnt[2];
  assign cnt_d = r_cnt[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmux_4way.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmux_4way
// Purpose  : Self-checking bench for dmux_4way. It applies a table of
//            directed vectors and then runs hand-written sequences for the
//            idle-select and counter corner cases. The counter sequence is
//            built only when DMUX_4WAY_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmux_4way;

  localparam int WIDTH = 4;
`ifdef DMUX_4WAY_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             s1, s2, in_vld;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       out_vld;
`ifdef DMUX_4WAY_CNT_EN
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef DMUX_4WAY_CNT_EN
  dmux_4way #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .s1(s1), .s2(s2), .in_vld(in_vld),
    .a(a), .b(b), .c(c), .d(d), .out_vld(out_vld),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
  );
`else
  dmux_4way #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .s1(s1), .s2(s2), .in_vld(in_vld),
    .a(a), .b(b), .c(c), .d(d), .out_vld(out_vld)
  );
`endif

  typedef struct {
    logic             rst_n;
    logic             vld;
    logic [WIDTH-1:0] din;
    logic [1:0]       sel;
    logic [WIDTH-1:0] ea, eb, ec, ed;
    logic [3:0]       ev;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Inputs are driven on the falling edge. Outputs are sampled 1 ns after the
  // next rising edge.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] dd,
                      input logic [1:0] sel);
    @(negedge clk);
    rst_n  = r;
    in_vld = v;
    din    = dd;
    {s1, s2} = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int idx,
                         input logic [WIDTH-1:0] ea, eb, ec, ed,
                         input logic [3:0] ev);
    chk({name, ".a"}, idx, 32'(a), 32'(ea));
    chk({name, ".b"}, idx, 32'(b), 32'(eb));
    chk({name, ".c"}, idx, 32'(c), 32'(ec));
    chk({name, ".d"}, idx, 32'(d), 32'(ed));
    chk({name, ".vld"}, idx, 32'(out_vld), 32'(ev));
  endtask

  initial begin
    //            rst  vld din    sel    a      b      c      d      out_vld
    vecs[0]  = '{1'b0, 1'b1, 4'h1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000}; // reset
    vecs[1]  = '{1'b0, 1'b1, 4'h1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000};
    vecs[2]  = '{1'b1, 1'b1, 4'h1, 2'd0, 4'h1, 4'h0, 4'h0, 4'h0, 4'b0001}; // sweep
    vecs[3]  = '{1'b1, 1'b1, 4'h1, 2'd1, 4'h0, 4'h1, 4'h0, 4'h0, 4'b0010};
    vecs[4]  = '{1'b1, 1'b1, 4'h1, 2'd2, 4'h0, 4'h0, 4'h1, 4'h0, 4'b0100};
    vecs[5]  = '{1'b1, 1'b1, 4'h1, 2'd3, 4'h0, 4'h0, 4'h0, 4'h1, 4'b1000};
    vecs[6]  = '{1'b1, 1'b1, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001}; // din=0
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010};
    vecs[8]  = '{1'b1, 1'b1, 4'h0, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 2'd3, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000};
    vecs[10] = '{1'b1, 1'b0, 4'h1, 2'd3, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000}; // idle
    vecs[11] = '{1'b1, 1'b1, 4'h1, 2'd3, 4'h0, 4'h0, 4'h0, 4'h1, 4'b1000};
    vecs[12] = '{1'b1, 1'b1, 4'hA, 2'd0, 4'hA, 4'h0, 4'h0, 4'h0, 4'b0001};
    vecs[13] = '{1'b0, 1'b1, 4'h5, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000}; // mid rst
    vecs[14] = '{1'b1, 1'b1, 4'h5, 2'd1, 4'h0, 4'h5, 4'h0, 4'h0, 4'b0010};
    vecs[15] = '{1'b1, 1'b1, 4'hF, 2'd2, 4'h0, 4'h0, 4'hF, 4'h0, 4'b0100};
    vecs[16] = '{1'b1, 1'b0, 4'hF, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000};

    rst_n = 1'b0; in_vld = 1'b0; din = '0; s1 = 1'b0; s2 = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst_n, vecs[i].vld, vecs[i].din, vecs[i].sel);
      chk_all("vec", i, vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed, vecs[i].ev);
    end

    // An unknown select while idle must leave every output at zero.
    step(1'b1, 1'b1, 4'h7, 2'd1);
    chk_all("pre_idle_x", 0, 4'h0, 4'h7, 4'h0, 4'h0, 4'b0010);
    @(negedge clk);
    in_vld = 1'b0; din = 4'h7; s1 = 1'bx; s2 = 1'bx;
    @(posedge clk); #1;
    chk_all("idle_x", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);

    // A new select takes effect on the very next valid beat.
    step(1'b1, 1'b1, 4'h3, 2'd3);
    chk_all("bb0", 0, 4'h0, 4'h0, 4'h0, 4'h3, 4'b1000);
    step(1'b1, 1'b1, 4'h9, 2'd0);
    chk_all("bb1", 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'b0001);

`ifdef DMUX_4WAY_CNT_EN
    // Counter saturation with CNT_W=2.
    step(1'b0, 1'b0, 4'h0, 2'd0);
    chk("cnt_rst_b", 0, 32'(cnt_b), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 4'h1, 2'd1);
      chk("cnt_b", k, 32'(cnt_b), (k < 3) ? 32'(k) : 32'd3);
    end
    chk("cnt_a", 0, 32'(cnt_a), 32'd0);
    chk("cnt_c", 0, 32'(cnt_c), 32'd0);
    chk("cnt_d", 0, 32'(cnt_d), 32'd0);
    step(1'b1, 1'b0, 4'h1, 2'd1);
    chk("cnt_b_hold", 0, 32'(cnt_b), 32'd3);
    step(1'b1, 1'b1, 4'h1, 2'd3);
    chk("cnt_d1", 0, 32'(cnt_d), 32'd1);
    step(1'b0, 1'b1, 4'h1, 2'd1);
    chk("cnt_clr_b", 0, 32'(cnt_b), 32'd0);
    chk("cnt_clr_d", 0, 32'(cnt_d), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
